// File: rtl/sum_ascii_pkg.sv
// Shared types and constants for the sum-to-ASCII UART framer.
package sum_ascii_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV      = 3'd1,
    SEND      = 3'd2,
    WAIT_RISE = 3'd3,
    WAIT_FALL = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int FRAME_LEN_DIGITS = 2;
  localparam int FRAME_LEN_CRLF   = 4;

  function automatic int frame_len(input bit send_crlf);
    int len;
    if (send_crlf) begin
      len = FRAME_LEN_CRLF;
    end else begin
      len = FRAME_LEN_DIGITS;
    end
    return len;
  endfunction

  // Byte at position idx of a frame: tens digit, ones digit, CR, LF.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [1:0] tens,
                                            input logic [3:0] ones);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ASCII_ZERO + {6'd0, tens};
      2'd1:    b = ASCII_ZERO + {4'd0, ones};
      2'd2:    b = ASCII_CR;
      2'd3:    b = ASCII_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sum_ascii_framer_if.sv
// Enable/busy byte handshake between the framer and the UART transmitter.
interface sum_ascii_framer_if;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;

  modport master (output tx_data, output tx_en, input tx_busy);
  modport slave  (input tx_data, input tx_en, output tx_busy);
endinterface

// File: rtl/bin_to_dec2.sv
// Combinational binary (0..31) to two decimal digits using compare-subtract.
module bin_to_dec2 #(
  parameter int SUM_W = 5
) (
  input  logic [SUM_W-1:0] bin,
  output logic [1:0]       tens,
  output logic [3:0]       ones
);

  localparam int RW = (SUM_W < 5) ? 5 : SUM_W;

  logic [RW-1:0] bin_w_s;
  logic [RW-1:0] rem1_s;

  // Subtract 20 then 10; each successful step sets one bit of the tens digit.
  always_comb begin
    bin_w_s = RW'(bin);
    if (bin_w_s >= RW'(20)) begin
      rem1_s  = bin_w_s - RW'(20);
      tens[1] = 1'b1;
    end else begin
      rem1_s  = bin_w_s;
      tens[1] = 1'b0;
    end
    if (rem1_s >= RW'(10)) begin
      ones    = 4'(rem1_s - RW'(10));
      tens[0] = 1'b1;
    end else begin
      ones    = 4'(rem1_s);
      tens[0] = 1'b0;
    end
  end

endmodule

// File: rtl/sum_ascii_framer.sv
// Captures the adder sum, converts it to ASCII decimal and streams the digits
// (plus optional CR LF) to the UART transmitter over the enable/busy handshake.
module sum_ascii_framer
  import sum_ascii_pkg::*;
#(
  parameter int SUM_W     = 5,
  parameter int SEND_CRLF = 1,
  parameter int BUSY_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SUM_W-1:0]   sum,
  output logic               busy,
  output logic               done,
  sum_ascii_framer_if.master tx
);

  localparam int               CNT_W    = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_WAIT);
  localparam logic [1:0]       LAST_IDX = 2'(frame_len(SEND_CRLF != 0) - 1);

  state_e             state_r, state_next_s;
  logic [SUM_W-1:0]   sum_r, sum_next_s;
  logic [1:0]         tens_r, tens_next_s, tens_s;
  logic [3:0]         ones_r, ones_next_s, ones_s;
  logic [1:0]         idx_r, idx_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic [7:0]         tx_data_r, tx_data_next_s;
  logic               tx_en_r, tx_en_next_s;
  logic               busy_r, busy_next_s;
  logic               done_r, done_next_s;

  bin_to_dec2 #(.SUM_W(SUM_W)) u_conv (
    .bin  (sum_r),
    .tens (tens_s),
    .ones (ones_s)
  );

  // Next-state and next-output decode; tx_en is decided one cycle ahead so it
  // leaves the block as a register.
  always_comb begin
    state_next_s   = state_r;
    sum_next_s     = sum_r;
    tens_next_s    = tens_r;
    ones_next_s    = ones_r;
    idx_next_s     = idx_r;
    cnt_next_s     = cnt_r;
    tx_data_next_s = tx_data_r;
    tx_en_next_s   = 1'b0;
    busy_next_s    = busy_r;
    done_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          sum_next_s   = sum;
          busy_next_s  = 1'b1;
          state_next_s = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        tens_next_s    = tens_s;
        ones_next_s    = ones_s;
        idx_next_s     = 2'd0;
        tx_data_next_s = frame_byte(2'd0, tens_s, ones_s);
        tx_en_next_s   = ~tx.tx_busy;
        state_next_s   = SEND;
      end
      SEND: begin
        if (tx_en_r) begin
          cnt_next_s   = {CNT_W{1'b0}};
          state_next_s = WAIT_RISE;
        end else if (!tx.tx_busy) begin
          tx_en_next_s = 1'b1;
        end else begin
          state_next_s = SEND;
        end
      end
      WAIT_RISE: begin
        // The first cycle here is the transmitter's sampling cycle, so the
        // timeout allows BUSY_WAIT cycles beyond it.
        if (tx.tx_busy || (cnt_r == CNT_MAX)) begin
          state_next_s = WAIT_FALL;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      WAIT_FALL: begin
        if (!tx.tx_busy) begin
          if (idx_r == LAST_IDX) begin
            done_next_s  = 1'b1;
            state_next_s = DONE;
          end else begin
            idx_next_s     = idx_r + 2'd1;
            tx_data_next_s = frame_byte(idx_r + 2'd1, tens_r, ones_r);
            tx_en_next_s   = 1'b1;
            state_next_s   = SEND;
          end
        end else begin
          state_next_s = WAIT_FALL;
        end
      end
      DONE: begin
        busy_next_s  = 1'b0;
        state_next_s = IDLE;
      end
      default: begin
        busy_next_s  = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      sum_r     <= {SUM_W{1'b0}};
      tens_r    <= 2'd0;
      ones_r    <= 4'd0;
      idx_r     <= 2'd0;
      cnt_r     <= {CNT_W{1'b0}};
      tx_data_r <= 8'h00;
      tx_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      sum_r     <= sum_next_s;
      tens_r    <= tens_next_s;
      ones_r    <= ones_next_s;
      idx_r     <= idx_next_s;
      cnt_r     <= cnt_next_s;
      tx_data_r <= tx_data_next_s;
      tx_en_r   <= tx_en_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
    end
  end

  assign tx.tx_data = tx_data_r;
  assign tx.tx_en   = tx_en_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_sum_ascii_framer.sv
// Directed and randomised frames against a decimal-text reference model, with
// CR LF and digits-only framers sharing the same stimulus.
module tb_sum_ascii_framer;

  localparam int BUSY_WAIT = 4;
  localparam int UART_BUSY = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] sum;
  logic       busy_a, done_a, busy_b, done_b;
  logic       force_hi, stuck;
  int         ucnt_a = 0, ucnt_b = 0;
  int         cyc = 0;

  int         n_checks = 0, n_fail = 0;
  logic [7:0] qa_data[$], qb_data[$];
  int         qa_cyc[$], qb_cyc[$];
  int         done_a_cnt = 0, done_b_cnt = 0, done_a_cyc = 0, done_b_cyc = 0;

  sum_ascii_framer_if tx_a ();
  sum_ascii_framer_if tx_b ();

  sum_ascii_framer #(.SUM_W(5), .SEND_CRLF(1), .BUSY_WAIT(BUSY_WAIT)) dut_a (
    .clk(clk), .reset(reset), .start(start), .sum(sum),
    .busy(busy_a), .done(done_a), .tx(tx_a));

  sum_ascii_framer #(.SUM_W(5), .SEND_CRLF(0), .BUSY_WAIT(BUSY_WAIT)) dut_b (
    .clk(clk), .reset(reset), .start(start), .sum(sum),
    .busy(busy_b), .done(done_b), .tx(tx_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for UART_BUSY cycles starting the cycle after tx_en.
  always @(posedge clk) begin
    if (tx_a.tx_en && ucnt_a == 0 && !stuck) ucnt_a <= UART_BUSY;
    else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
    if (tx_b.tx_en && ucnt_b == 0 && !stuck) ucnt_b <= UART_BUSY;
    else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
  end
  assign tx_a.tx_busy = force_hi || (ucnt_a != 0);
  assign tx_b.tx_busy = force_hi || (ucnt_b != 0);

  always @(negedge clk) begin
    if (tx_a.tx_en) begin qa_data.push_back(tx_a.tx_data); qa_cyc.push_back(cyc); end
    if (tx_b.tx_en) begin qb_data.push_back(tx_b.tx_data); qb_cyc.push_back(cyc); end
    if (done_a) begin done_a_cnt++; done_a_cyc = cyc; end
    if (done_b) begin done_b_cnt++; done_b_cyc = cyc; end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int s, input int k);
    logic [7:0] b;
    case (k)
      0:       b = 8'(48 + s / 10);
      1:       b = 8'(48 + s % 10);
      2:       b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1000;
  endfunction

  task automatic clear_capture;
    qa_data.delete(); qb_data.delete(); qa_cyc.delete(); qb_cyc.delete();
  endtask

  task automatic check_frame(input int s);
    check("len_a", qa_data.size(), 4);
    check("len_b", qb_data.size(), 2);
    for (int k = 0; k < 4; k++)
      check($sformatf("byte_a%0d_sum%0d", k, s),
            (k < qa_data.size()) ? {24'd0, qa_data[k]} : 32'hFFFF_FFFF, {24'd0, exp_byte(s, k)});
    for (int k = 0; k < 2; k++)
      check($sformatf("byte_b%0d_sum%0d", k, s),
            (k < qb_data.size()) ? {24'd0, qb_data[k]} : 32'hFFFF_FFFF, {24'd0, exp_byte(s, k)});
  endtask

  task automatic wait_both_done(input int base_a, input int base_b);
    int n = 0;
    while ((done_a_cnt == base_a || done_b_cnt == base_b) && n < 400) begin
      tick;
      n++;
    end
    check("done_a_seen", done_a_cnt, base_a + 1);
    check("done_b_seen", done_b_cnt, base_b + 1);
  endtask

  task automatic run_frame(input int s, input bit stuck_mode);
    int drive_cyc, base_a, base_b;
    stuck = stuck_mode;
    clear_capture();
    base_a = done_a_cnt; base_b = done_b_cnt;
    sum = 5'(s); start = 1'b1; drive_cyc = cyc;
    tick;
    start = 1'b0;
    check("busy_rise", {31'd0, busy_a}, 32'd1);
    wait_both_done(base_a, base_b);
    check_frame(s);
    check("first_en_latency", (qa_cyc.size() > 0) ? qa_cyc[0] - drive_cyc : -1, 2);
    if (stuck_mode) begin
      for (int k = 1; k < 4; k++)
        check($sformatf("gap_a%0d", k), (k < qa_cyc.size()) ? qa_cyc[k] - qa_cyc[k-1] : -1,
              BUSY_WAIT + 3);
      check("done_gap_a_stuck", done_a_cyc - last_of(qa_cyc), BUSY_WAIT + 3);
      check("done_gap_b_stuck", done_b_cyc - last_of(qb_cyc), BUSY_WAIT + 3);
    end else begin
      // busy rises after tx_en, falls UART_BUSY cycles later, done one cycle after that
      check("done_gap_a", done_a_cyc - last_of(qa_cyc), UART_BUSY + 2);
      check("done_gap_b", done_b_cyc - last_of(qb_cyc), UART_BUSY + 2);
    end
    for (int i = 0; i < 3 && cyc <= done_a_cyc; i++) tick;
    check("busy_after_done", {31'd0, busy_a}, 32'd0);
    repeat (3) tick;
    check("single_done_a", done_a_cnt, base_a + 1);
    check("single_done_b", done_b_cnt, base_b + 1);
    stuck = 1'b0;
  endtask

  initial begin
    int base_a, base_b, n, s, rel_cyc;
    reset = 1'b1; start = 1'b0; sum = 5'd0; force_hi = 1'b0; stuck = 1'b0;
    repeat (3) tick;
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_tx_en", {31'd0, tx_a.tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, tx_a.tx_data}, 32'd0);
    reset = 1'b0;
    tick;
    check("idle_busy_b", {31'd0, busy_b}, 32'd0);

    run_frame(7, 1'b0);
    run_frame(30, 1'b0);
    run_frame(31, 1'b0);
    run_frame(0, 1'b0);
    run_frame(15, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(int'($urandom_range(0, 31)), 1'b0);
    run_frame(19, 1'b1);
    run_frame(int'($urandom_range(0, 31)), 1'b1);

    // tx_busy held high at start, then a second start mid-frame
    clear_capture();
    base_a = done_a_cnt; base_b = done_b_cnt;
    force_hi = 1'b1;
    sum = 5'd23; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (15) tick;
    check("hold_no_en", qa_data.size(), 0);
    check("hold_busy", {31'd0, busy_a}, 32'd1);
    force_hi = 1'b0; rel_cyc = cyc;
    n = 0;
    while (qa_data.size() == 0 && n < 50) begin tick; n++; end
    check("release_latency", (qa_cyc.size() > 0) ? qa_cyc[0] - rel_cyc : -1, 1);
    sum = 5'd4; start = 1'b1;
    tick;
    start = 1'b0;
    wait_both_done(base_a, base_b);
    repeat (20) tick;
    check_frame(23);
    check("mid_start_done_a", done_a_cnt, base_a + 1);

    // reset while the second byte is in WAIT_FALL
    clear_capture();
    base_a = done_a_cnt; base_b = done_b_cnt;
    sum = 5'd21; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (qa_data.size() < 2 && n < 100) begin tick; n++; end
    repeat (4) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_tx_en", {31'd0, tx_a.tx_en}, 32'd0);
    check("abort_busy_a", {31'd0, busy_a}, 32'd0);
    check("abort_busy_b", {31'd0, busy_b}, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    repeat (20) tick;
    check("abort_no_done_a", done_a_cnt, base_a);
    check("abort_no_done_b", done_b_cnt, base_b);
    check("abort_bytes_a", qa_data.size(), 2);
    s = 9;
    run_frame(s, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
